link_ddr_downstream_token_out: RTL and testbench
================================================

Name: link_ddr_downstream_token_out

Overview:
- Receive-side neighbour of the DDR link upstream: consumes the per-channel beats the upstream drives on io_valid/io_data and reassembles them into core-width words.
- Buffers assembled words in a small FIFO and presents them to the core via a valid/yumi handshake.
- Returns credit to the upstream as toggling token lines: one toggle per 2^LG_CREDIT_TO_TOKEN_DECIMATION words the core consumes.
- Single-clock model of the downstream path, used in composition verification against the upstream TOKEN_IN behaviour.

Parameters:
- CHANNEL_WIDTH, 8, bits per channel beat
- NUM_CHANNELS, 2, parallel link channels
- CORE_DATA_WIDTH, 64, assembled word width; must be a multiple of CHANNEL_WIDTH*NUM_CHANNELS
- LG_FIFO_DEPTH, 3, log2 of receive FIFO depth in words
- LG_CREDIT_TO_TOKEN_DECIMATION, 3, log2 of words consumed per token toggle; must be <= LG_FIFO_DEPTH

Ports:
- clk  in  1  link/core clock
- rst  in  1  synchronous, active-high reset
- io_valid_i  in  NUM_CHANNELS  per-channel beat valid
- io_data_i  in  NUM_CHANNELS*CHANNEL_WIDTH  per-channel beat data; channel c occupies bits [c*CHANNEL_WIDTH +: CHANNEL_WIDTH]
- core_valid_o  out  1  FIFO head valid
- core_data_o  out  CORE_DATA_WIDTH  FIFO head word
- core_yumi_i  in  1  core consumes head this cycle; legal only when core_valid_o=1
- io_token_r_o  out  NUM_CHANNELS  registered token lines, toggled per credit batch
- error_o  out  1  sticky protocol error (see Optional Feature)

Interface decision: one clock (clk); reset rst is synchronous and active-high.

Behaviour:
- Beat counts:
  - BEATS = CORE_DATA_WIDTH/(CHANNEL_WIDTH*NUM_CHANNELS); 4 at the defaults.
  - Beat counter width is clog2(BEATS), minimum 1 bit.
- Reset (rst high at a clk edge):
  - Beat counter = 0; partial word discarded.
  - FIFO emptied, so core_valid_o=0. core_data_o is don't-care but the model drives 0.
  - Credit counter = 0, io_token_r_o = 0, error_o = 0.
  - Applies equally mid-word and mid-batch.
- Assembly FSM:
  - States are ASSEMBLE(k), k = beat counter 0..BEATS-1.
  - A beat is accepted when all io_valid_i bits are 1.
  - On acceptance, channel c's data is written to word bits [(c*BEATS+k)*CHANNEL_WIDTH +: CHANNEL_WIDTH], and k advances.
  - At k=BEATS-1 the completed word is enqueued and k wraps to 0.
  - io_valid_i all-zero: hold state.
  - io_valid_i partially set (channel skew): beat ignored, k held; counts as a protocol error.
- FIFO:
  - Depth 2^LG_FIFO_DEPTH, registered.
  - Word completed at edge N is visible as core_valid_o=1 in cycle N+1.
  - Dequeue on core_yumi_i & core_valid_o.
  - Enqueue and dequeue in the same cycle are allowed at any occupancy, including full: the dequeue frees the slot.
  - Completion while full with no dequeue: the word is dropped (overflow error). Upstream credits make this illegal.
  - core_yumi_i while empty: ignored (underflow error).
- Credit/token:
  - Credit counter is LG_CREDIT_TO_TOKEN_DECIMATION bits and increments on every dequeue.
  - When it wraps from all-ones to 0, every io_token_r_o bit toggles on the same edge.
  - Latency: the yumi of the 8th word (defaults) at cycle T produces the toggle visible at T+1.
  - Counter arithmetic is modulo 2^LG_CREDIT_TO_TOKEN_DECIMATION.
- No combinational path from any input to any output except core_data_o from FIFO read address.

Optional Feature:
- Macro LINK_DDR_DOWNSTREAM_CHECK_EN.
- Defined:
  - error_o is set sticky, one cycle after any of: partial io_valid_i, overflow drop, or yumi while empty.
  - error_o clears only on rst.
  - Simulation assertions fire on the same conditions.
- Undefined:
  - error_o is tied 0 and no check logic is present.
  - Data-path behaviour is identical: partial beats are ignored, overflow words dropped, empty yumi ignored.

Decomposition:
- Shared package link_ddr_downstream_pkg holds:
  - BEATS computation function
  - beat-counter width constant
  - error-cause enum (ERR_NONE, ERR_SKEW, ERR_OVERFLOW, ERR_UNDERFLOW), used internally and by the bench scoreboard
- One sub-module: link_ddr_downstream_fifo, a 1-clock two-pointer FIFO with full/empty flags and same-cycle enq/deq.

Test Plan:
- Word assembly: rst then 4 beats with io_valid_i=2'b11, ch0 = 0x11,0x22,0x33,0x44 and ch1 = 0x55,0x66,0x77,0x88 -> core_valid_o=1 the cycle after beat 4, core_data_o=64'h8877665544332211.
- Token batch: 8 words enqueued and consumed one per cycle -> io_token_r_o 2'b00->2'b11 exactly one cycle after the 8th yumi; after 16 yumis it returns to 2'b00.
- Full FIFO, simultaneous enq/deq: fill 8 words, hold yumi=0, complete a 9th word while asserting yumi -> no drop, occupancy stays 8, error_o=0.
- Overflow: 8 words held, 9th completes with yumi=0 -> 9th word absent from output; with CHECK_EN, error_o=1 next cycle.
- Channel skew: io_valid_i=2'b01 for one cycle mid-word -> beat counter unchanged, assembled data unaffected; with CHECK_EN, error_o=1.
- Reset mid-operation: rst after 2 beats with 3 words queued and credit counter at 5 -> next cycle core_valid_o=0, io_token_r_o=0; the next 4 beats form a fresh word, and the token toggles after 8 further yumis.

Source files
------------

// File: rtl/link_ddr_downstream_pkg.sv
// Shared definitions for the DDR link downstream (receive) path.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package link_ddr_downstream_pkg;

    // Reason a cycle was flagged as a protocol violation.
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_SKEW      = 2'd1,
        ERR_OVERFLOW  = 2'd2,
        ERR_UNDERFLOW = 2'd3
    } err_cause_e;

    // Number of link beats that make up one core word.
    function automatic int beats_f(input int core_w, input int chan_w, input int num_ch);
        return core_w / (chan_w * num_ch);
    endfunction

    // Beat counter width; a single-beat word still gets a 1-bit counter.
    function automatic int beat_cnt_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int DEFAULT_BEATS      = beats_f(64, 8, 2);
    localparam int DEFAULT_BEAT_CNT_W = beat_cnt_w_f(DEFAULT_BEATS);

endpackage

// File: rtl/link_ddr_downstream_fifo.sv
// Single-clock two-pointer FIFO holding assembled words for the core.
// Latency: a word written at edge N is visible at the head in cycle N+1.
// Backpressure: enq_rdy_o is low only when full with no dequeue this cycle.
module link_ddr_downstream_fifo #(
    parameter int WIDTH    = 64,
    parameter int LG_DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_vld_i,
    input  logic [WIDTH-1:0] enq_dat_i,
    output logic             enq_rdy_o,
    output logic             deq_vld_o,
    output logic [WIDTH-1:0] deq_dat_o,
    input  logic             deq_rdy_i
);

    localparam int DEPTH = 1 << LG_DEPTH;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [LG_DEPTH:0] wptr_q, wptr_d;
    logic [LG_DEPTH:0] rptr_q, rptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [WIDTH-1:0]  mem_d [DEPTH];
    logic              empty;
    logic              full;
    logic              do_enq;
    logic              do_deq;

    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[LG_DEPTH] != rptr_q[LG_DEPTH]) &&
                       (wptr_q[LG_DEPTH-1:0] == rptr_q[LG_DEPTH-1:0]);
    assign do_deq    = deq_rdy_i & ~empty;
    // A dequeue in the same cycle frees the slot, so full does not block it.
    assign enq_rdy_o = ~full | do_deq;
    assign do_enq    = enq_vld_i & enq_rdy_o;
    assign deq_vld_o = ~empty;
    assign deq_dat_o = empty ? '0 : mem_q[rptr_q[LG_DEPTH-1:0]];

    // Next pointers and storage contents.
    always_comb begin
        wptr_d = wptr_q + {{LG_DEPTH{1'b0}}, do_enq};
        rptr_d = rptr_q + {{LG_DEPTH{1'b0}}, do_deq};
        mem_d  = mem_q;
        if (do_enq) begin
            mem_d[wptr_q[LG_DEPTH-1:0]] = enq_dat_i;
        end
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: slots are only read after being written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/link_ddr_downstream_token_out.sv
// DDR link receive path: reassembles channel beats into core words, queues them, returns credit tokens.
// Latency: word visible one cycle after its last beat; token toggles one cycle after the batch-closing yumi.
// Backpressure: none toward the link (credits prevent overflow); core pulls with valid/yumi. Optional checks: LINK_DDR_DOWNSTREAM_CHECK_EN.
module link_ddr_downstream_token_out
    import link_ddr_downstream_pkg::*;
#(
    parameter int CHANNEL_WIDTH                 = 8,
    parameter int NUM_CHANNELS                  = 2,
    parameter int CORE_DATA_WIDTH               = 64,
    parameter int LG_FIFO_DEPTH                 = 3,
    parameter int LG_CREDIT_TO_TOKEN_DECIMATION = 3
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_CHANNELS-1:0]               io_valid_i,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0] io_data_i,
    output logic                                  core_valid_o,
    output logic [CORE_DATA_WIDTH-1:0]            core_data_o,
    input  logic                                  core_yumi_i,
    output logic [NUM_CHANNELS-1:0]               io_token_r_o,
    output logic                                  error_o
);

    localparam int BEATS = beats_f(CORE_DATA_WIDTH, CHANNEL_WIDTH, NUM_CHANNELS);
    localparam int BCW   = beat_cnt_w_f(BEATS);
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);
    // A zero-width decimation still needs a 1-bit counter; it simply never leaves 0.
    localparam int CRW = (LG_CREDIT_TO_TOKEN_DECIMATION > 0) ? LG_CREDIT_TO_TOKEN_DECIMATION : 1;
    localparam logic [CRW-1:0] CRED_MAX = CRW'((1 << LG_CREDIT_TO_TOKEN_DECIMATION) - 1);

    logic [BCW-1:0]             beat_q,  beat_d;
    logic [CORE_DATA_WIDTH-1:0] word_q,  word_d;
    logic [CRW-1:0]             cred_q,  cred_d;
    logic [NUM_CHANNELS-1:0]    token_q, token_d;
    logic                       beat_acc;
    logic                       word_done;
    logic                       fifo_rdy;
    logic                       deq;

    // A beat only counts when every channel presents it; skewed beats are dropped.
    assign beat_acc  = &io_valid_i;
    assign word_done = beat_acc && (beat_q == LAST_BEAT);
    assign deq       = core_yumi_i & core_valid_o;

    // Assembly: channel c beat k lands in slice (c*BEATS + k); enqueue uses word_d so the last beat is included.
    always_comb begin
        beat_d = beat_q;
        word_d = word_q;
        if (beat_acc) begin
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                for (int k = 0; k < BEATS; k++) begin
                    if (beat_q == BCW'(k)) begin
                        word_d[(c*BEATS + k)*CHANNEL_WIDTH +: CHANNEL_WIDTH] =
                            io_data_i[c*CHANNEL_WIDTH +: CHANNEL_WIDTH];
                    end
                end
            end
            beat_d = word_done ? '0 : beat_q + 1'b1;
        end
    end

    // Credit: count dequeues, toggle all token lines when the counter wraps.
    always_comb begin
        cred_d  = cred_q;
        token_d = token_q;
        if (deq) begin
            if (cred_q == CRED_MAX) begin
                cred_d  = '0;
                token_d = ~token_q;
            end else begin
                cred_d = cred_q + 1'b1;
            end
        end
    end

    // State registers for assembly and credit return.
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q  <= '0;
            word_q  <= '0;
            cred_q  <= '0;
            token_q <= '0;
        end else begin
            beat_q  <= beat_d;
            word_q  <= word_d;
            cred_q  <= cred_d;
            token_q <= token_d;
        end
    end

    assign io_token_r_o = token_q;

    link_ddr_downstream_fifo #(
        .WIDTH    (CORE_DATA_WIDTH),
        .LG_DEPTH (LG_FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .enq_vld_i (word_done),
        .enq_dat_i (word_d),
        .enq_rdy_o (fifo_rdy),
        .deq_vld_o (core_valid_o),
        .deq_dat_o (core_data_o),
        .deq_rdy_i (core_yumi_i)
    );

`ifdef LINK_DDR_DOWNSTREAM_CHECK_EN
    err_cause_e err_cause;
    logic       error_q, error_d;

    // Classify this cycle's protocol violation (at most one is reported, all set the flag).
    always_comb begin
        err_cause = ERR_NONE;
        if ((io_valid_i != '0) && !beat_acc) begin
            err_cause = ERR_SKEW;
        end else if (word_done && !fifo_rdy) begin
            err_cause = ERR_OVERFLOW;
        end else if (core_yumi_i && !core_valid_o) begin
            err_cause = ERR_UNDERFLOW;
        end
        error_d = error_q | (err_cause != ERR_NONE);
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;

`ifndef SYNTHESIS
    // Flag each violation in simulation as it happens.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ((io_valid_i == '0) || beat_acc)
                else $error("link_ddr_downstream: channel skew on io_valid_i");
            assert (!(word_done && !fifo_rdy))
                else $error("link_ddr_downstream: receive FIFO overflow, word dropped");
            assert (!(core_yumi_i && !core_valid_o))
                else $error("link_ddr_downstream: core_yumi_i while empty");
        end
    end
`endif
`else
    assign error_o = 1'b0;
    // FIFO readiness only feeds the checker; sink it when checks are compiled out.
    logic unused_fifo_rdy;
    assign unused_fifo_rdy = fifo_rdy;
`endif

endmodule

// File: tb/tb_link_ddr_downstream_token_out.sv
// Self-checking bench for link_ddr_downstream_token_out at default parameters.
// Latency: inputs applied after negedge, outputs compared at the following negedge.
// Backpressure: core_yumi_i driven by vectors, directed sequences and random rates.
module tb_link_ddr_downstream_token_out;
    import link_ddr_downstream_pkg::*;

`ifdef LINK_DDR_DOWNSTREAM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [1:0]  io_valid_i;
    logic [15:0] io_data_i;
    logic        core_valid_o;
    logic [63:0] core_data_o;
    logic        core_yumi_i;
    logic [1:0]  io_token_r_o;
    logic        error_o;

    int n_tests = 0;
    int n_fail  = 0;

    link_ddr_downstream_token_out dut (
        .clk          (clk),
        .rst          (rst),
        .io_valid_i   (io_valid_i),
        .io_data_i    (io_data_i),
        .core_valid_o (core_valid_o),
        .core_data_o  (core_data_o),
        .core_yumi_i  (core_yumi_i),
        .io_token_r_o (io_token_r_o),
        .error_o      (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [63:0] mq[$];          // words the core should see, head first
    int          m_beat;         // beats collected for the current word
    bit   [7:0]  m_bytes[2][4];  // [channel][beat]
    int          m_cons;         // words consumed since reset
    bit          m_err;
    err_cause_e  m_cause;

    task automatic model_reset();
        mq.delete();
        m_beat  = 0;
        m_cons  = 0;
        m_err   = 1'b0;
        m_cause = ERR_NONE;
    endtask

    task automatic model_step(input logic [1:0] v, input logic [15:0] d, input logic y);
        int          sz;
        bit          dq;
        bit          done;
        logic [63:0] w;
        sz      = mq.size();
        dq      = y && (sz > 0);
        done    = 1'b0;
        w       = '0;
        m_cause = ERR_NONE;
        if (v == 2'b11) begin
            m_bytes[0][m_beat] = d[7:0];
            m_bytes[1][m_beat] = d[15:8];
            if (m_beat == 3) begin
                done   = 1'b1;
                m_beat = 0;
            end else begin
                m_beat++;
            end
        end else if (v != 2'b00) begin
            m_cause = ERR_SKEW;
        end
        if (done) begin
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 4; k++)
                    w[(c*4 + k)*8 +: 8] = m_bytes[c][k];
        end
        if (dq) begin
            void'(mq.pop_front());
            m_cons++;
        end
        if (done) begin
            if (sz < 8 || dq) mq.push_back(w);
            else m_cause = ERR_OVERFLOW;
        end
        if (y && sz == 0) m_cause = ERR_UNDERFLOW;
        if (CHK && m_cause != ERR_NONE) m_err = 1'b1;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [1:0] exp_tok;
        exp_tok = (((m_cons / 8) % 2) == 1) ? 2'b11 : 2'b00;
        check("model_core_valid", core_valid_o, (mq.size() > 0));
        check("model_core_data", core_data_o, (mq.size() > 0) ? mq[0] : 64'h0);
        check("model_token", io_token_r_o, exp_tok);
        check("model_error", error_o, m_err);
    endtask

    // One clock: drive at negedge, update model at posedge, compare at next negedge.
    task automatic cycle(input logic [1:0] v, input logic [15:0] d, input logic y,
                         input logic r = 1'b0);
        io_valid_i  = v;
        io_data_i   = d;
        core_yumi_i = y;
        rst         = r;
        @(posedge clk);
        if (r) model_reset();
        else   model_step(v, d, y);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        cycle(2'b00, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic send_word(input logic [63:0] w, input logic y_last);
        for (int k = 0; k < 4; k++)
            cycle(2'b11, {w[(4+k)*8 +: 8], w[k*8 +: 8]}, (k == 3) ? y_last : 1'b0);
    endtask

    // Consume until the model says empty (bounded); report count and last word seen.
    task automatic drain(output int n, output logic [63:0] last, output bit seen,
                         input logic [63:0] probe);
        n    = 0;
        last = '0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mq.size() == 0) break;
            last = core_data_o;
            if (core_data_o === probe) seen = 1'b1;
            cycle(2'b00, 16'h0, 1'b1);
            n++;
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // ---------------- vectors ----------------
    typedef struct {
        logic [1:0]  v;
        logic [15:0] d;
        logic        y;
        logic        ev;
        logic [63:0] ed;
        logic [1:0]  et;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          n;
        logic [63:0] last;
        bit          seen;
        logic [63:0] w9;
        logic [63:0] ws[8];
        int          ypct;

        tbl[0] = '{2'b11, 16'h5511, 1'b0, 1'b0, 64'h0, 2'b00};
        tbl[1] = '{2'b11, 16'h6622, 1'b0, 1'b0, 64'h0, 2'b00};
        tbl[2] = '{2'b01, 16'hFFFF, 1'b0, 1'b0, 64'h0, 2'b00};  // skewed beat mid-word
        tbl[3] = '{2'b11, 16'h7733, 1'b0, 1'b0, 64'h0, 2'b00};
        tbl[4] = '{2'b11, 16'h8844, 1'b0, 1'b1, 64'h8877665544332211, 2'b00};
        tbl[5] = '{2'b00, 16'h0000, 1'b0, 1'b1, 64'h8877665544332211, 2'b00};
        tbl[6] = '{2'b00, 16'h0000, 1'b1, 1'b0, 64'h0, 2'b00};
        tbl[7] = '{2'b00, 16'h0000, 1'b1, 1'b0, 64'h0, 2'b00};  // yumi while empty

        rst = 1'b1; io_valid_i = '0; io_data_i = '0; core_yumi_i = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state and word assembly vectors.
        do_reset();
        check("reset_valid", core_valid_o, 1'b0);
        check("reset_token", io_token_r_o, 2'b00);
        check("reset_error", error_o, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].y);
            check("vec_valid", core_valid_o, tbl[i].ev);
            check("vec_data", core_data_o, tbl[i].ed);
            check("vec_token", io_token_r_o, tbl[i].et);
        end
        check("skew_underflow_error", error_o, CHK);

        // Token batches: 8 words in, 8 yumis -> toggle; 8 more -> back.
        do_reset();
        for (int i = 0; i < 8; i++) send_word(rnd64(), 1'b0);
        check("batch_full_valid", core_valid_o, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(2'b00, 16'h0, 1'b1);
            check("batch1_token", io_token_r_o, (i == 7) ? 2'b11 : 2'b00);
        end
        for (int i = 0; i < 8; i++) send_word(rnd64(), 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(2'b00, 16'h0, 1'b1);
            check("batch2_token", io_token_r_o, (i == 7) ? 2'b00 : 2'b11);
        end

        // Full FIFO with simultaneous enqueue and dequeue: nothing dropped.
        do_reset();
        for (int i = 0; i < 8; i++) send_word(rnd64(), 1'b0);
        w9 = rnd64();
        send_word(w9, 1'b1);
        check("full_simul_error", error_o, 1'b0);
        drain(n, last, seen, w9);
        check("full_simul_count", n, 8);
        check("full_simul_last", last, w9);

        // Overflow: ninth word with no dequeue is dropped.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            ws[i] = rnd64();
            send_word(ws[i], 1'b0);
        end
        w9 = rnd64();
        send_word(w9, 1'b0);
        check("overflow_error", error_o, CHK);
        drain(n, last, seen, w9);
        check("overflow_count", n, 8);
        check("overflow_last", last, ws[7]);
        check("overflow_dropped", seen, 1'b0);

        // Reset mid-word, mid-batch with words queued.
        do_reset();
        for (int i = 0; i < 5; i++) send_word(rnd64(), 1'b0);
        for (int i = 0; i < 5; i++) cycle(2'b00, 16'h0, 1'b1);
        for (int i = 0; i < 3; i++) send_word(rnd64(), 1'b0);
        cycle(2'b11, 16'hA5A5, 1'b0);
        cycle(2'b11, 16'h5A5A, 1'b0);
        do_reset();
        check("midrst_valid", core_valid_o, 1'b0);
        check("midrst_token", io_token_r_o, 2'b00);
        check("midrst_error", error_o, 1'b0);
        ws[0] = rnd64();
        send_word(ws[0], 1'b0);
        check("midrst_fresh_word", core_data_o, ws[0]);
        for (int i = 1; i < 8; i++) send_word(rnd64(), 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(2'b00, 16'h0, 1'b1);
            check("midrst_token_batch", io_token_r_o, (i == 7) ? 2'b11 : 2'b00);
        end

        // Randomized traffic against the model, varying the core's consume rate.
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0: ypct = 5;
                1: ypct = 50;
                2: ypct = 20;
                default: ypct = 90;
            endcase
            for (int i = 0; i < 400; i++) begin
                logic [1:0] v;
                int         p;
                p = $urandom_range(0, 19);
                if (p < 13)      v = 2'b11;
                else if (p < 19) v = 2'b00;
                else             v = 2'($urandom_range(1, 2));
                cycle(v, 16'($urandom), ($urandom_range(0, 99) < ypct),
                      ($urandom_range(0, 299) == 0));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
